local_bus_word_target: RTL
==========================

LOCAL_BUS_WORD_TARGET -- requirements
Module: local_bus_word_target

Interface
REQ-001 Parameter WAIT_MIN, default 2: minimum STROBE cycles, range 1..15.
REQ-002 Parameter TIMEOUT, default 255: STROBE cycles before bus error, range 16..255; used only with TIMEOUT_EN.
REQ-003 CLK40  in  1  local bus clock; all logic on rising edge.
REQ-004 RESETn  in  1  reset, synchronous, active-low.
REQ-005 TSn  in  1  transfer start from the cycle initiator, active-low, one cycle wide.
REQ-006 SEL  in  1  address-decode hit for this target, qualified with TSn.
REQ-007 RnW  in  1  1 = read, 0 = write.
REQ-008 SIZ  in  2  01 byte, 10 word, 00 long, 11 line.
REQ-009 A  in  2  address bits 1..0.
REQ-010 D_IN  in  32  write data from the local bus.
REQ-011 D_OUT  out  32  read data to the local bus.
REQ-012 D_OE  out  1  enables the D_OUT drive.
REQ-013 TACKn  out  1  transfer acknowledge, active-low.
REQ-014 TEAn  out  1  transfer error acknowledge, active-low.
REQ-015 PORTSIZE  out  1  word-port indication; equals SEL combinationally.
REQ-016 P_CSn, P_UDSn, P_LDSn  out  1 each  peripheral chip select and upper/lower data strobes, active-low.
REQ-017 P_RnW  out  1  peripheral direction.
REQ-018 P_WDATA  out  16  peripheral write data.
REQ-019 P_RDATA  in  16  peripheral read data.
REQ-020 P_RDYn  in  1  peripheral ready, active-low, sampled synchronously.

Function
REQ-021 The block SHALL implement the states IDLE, SETUP, STROBE, ACK and RECOVER, with all outputs except PORTSIZE registered.
REQ-022 IDLE->SETUP SHALL occur on an edge with TSn=0 and SEL=1; at that edge RnW, SIZ, A and D_IN are latched.
REQ-023 In any state other than IDLE, TSn SHALL be ignored, and a TSn with SEL=0 SHALL be ignored in all states.
REQ-024 SETUP->STROBE SHALL occur unconditionally after 1 cycle; in STROBE, P_CSn=0, P_RnW=latched RnW, and a 4-bit wait counter starts at 0 and increments each cycle.
REQ-025 Strobes SHALL follow these rules: byte with A[0]=0 asserts UDS only; byte with A[0]=1 asserts LDS only; word, long or line asserts both.
REQ-026 Write lane select SHALL be: P_WDATA = latched D_IN[31:16] when A[1]=0 and D_IN[15:0] when A[1]=1, with byte data replicated onto both P_WDATA bytes.
REQ-027 STROBE->ACK SHALL occur when counter >= WAIT_MIN-1 and P_RDYn=0 on the same edge; on that edge P_RDATA is latched and P_CSn, P_UDSn and P_LDSn are deasserted.
REQ-028 In ACK, TACKn=0 for exactly 1 cycle, D_OUT={latched P_RDATA, latched P_RDATA}, and D_OE equals the latched RnW.
REQ-029 ACK->RECOVER SHALL occur after 1 cycle; RECOVER->IDLE SHALL occur after 1 cycle, with all outputs idle in RECOVER.
REQ-030 Minimum latency: with TSn sampled at edge N, WAIT_MIN=2 and P_RDYn held low, TACKn SHALL be low between edges N+3 and N+4, and the next TSn SHALL be accepted at N+5.
REQ-031 Long or line requests SHALL be serviced as a single word transfer on the upper word, since splitting is the initiator's job.
REQ-032 TACKn and TEAn SHALL never be low in the same cycle.

Reset
REQ-033 When RESETn=0 at an edge: state=IDLE, TACKn=1, TEAn=1, D_OE=0, D_OUT=0, P_CSn=P_UDSn=P_LDSn=1, P_RnW=1, P_WDATA=0, counters=0.
REQ-034 A reset in any state, including STROBE, SHALL abort the cycle without generating TACKn or TEAn.

Configuration
REQ-035 With macro TIMEOUT_EN defined: a 8-bit counter runs in STROBE; if P_RDYn is not sampled low within TIMEOUT cycles, the block goes to ACK with TEAn=0 (TACKn=1) for 1 cycle, D_OUT=32'hFFFFFFFF on reads, then RECOVER.
REQ-036 Without TIMEOUT_EN: the block stays in STROBE indefinitely until P_RDYn=0, TEAn is a constant 1, and the timeout counter does not exist.

Verification
REQ-037 Word read: SEL=1, A=00, SIZ=10, P_RDATA=16'h1234, P_RDYn=0 -> UDS=LDS=0 for 2 cycles, TACKn low at N+3 for 1 cycle, D_OUT=32'h12341234, D_OE=1.
REQ-038 Byte write: A=11, SIZ=01, D_IN=32'h000000AB -> only P_LDSn low, P_WDATA=16'hABAB, P_RnW=0, TACKn once, D_OE=0.
REQ-039 Wait states: P_RDYn released 5 cycles into STROBE -> TACKn delayed exactly 5 cycles beyond minimum; a second TSn during STROBE is ignored.
REQ-040 Back-to-back: TSn at N and again at N+5 -> both acknowledged; a TSn at N+4 is ignored.
REQ-041 Reset mid-STROBE: RESETn=0 for 1 edge -> next cycle all outputs idle, no TACKn/TEAn; a fresh TSn afterwards completes normally.
REQ-042 TIMEOUT_EN, TIMEOUT=16, P_RDYn held high -> TEAn low for 1 cycle after 16 STROBE cycles, D_OUT=32'hFFFFFFFF, TACKn stays high.

Source files
------------

// File: rtl/local_bus_word_target.sv
// local_bus_word_target
//   Word-wide (16-bit) peripheral target on a 32-bit local bus. A selected transfer
//   start is latched and run through SETUP, STROBE, ACK and RECOVER. The peripheral
//   sees one chip select, upper/lower data strobes and 16-bit write data. The
//   initiator gets a one-cycle TACKn with the peripheral read data replicated onto
//   both halves of D_OUT. Long and line requests are serviced as a single upper-word
//   transfer; splitting them is left to the initiator.
//
// Optional feature: define TIMEOUT_EN to add an 8-bit STROBE timeout. When it expires
//   the cycle ends with TEAn instead of TACKn. Without it, TEAn is tied high.
//
// Parameters
//   WAIT_MIN  minimum STROBE cycles (1..15)
//   TIMEOUT   STROBE cycles before bus error (16..255, TIMEOUT_EN only)
//
// Ports
//   CLK40     local bus clock; all logic on the rising edge
//   RESETn    synchronous active-low reset
//   TSn, SEL  transfer start (active-low) and address-decode hit
//   RnW, SIZ, A, D_IN  request attributes and write data, latched at start
//   D_OUT, D_OE        read data and its drive enable
//   TACKn, TEAn        transfer acknowledge / error acknowledge (active-low)
//   PORTSIZE           word-port indication, combinationally equal to SEL
//   P_CSn, P_UDSn, P_LDSn, P_RnW, P_WDATA  peripheral strobes, direction, write data
//   P_RDATA, P_RDYn    peripheral read data and ready (active-low)
module local_bus_word_target #(
    parameter int unsigned WAIT_MIN = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK40,
    input  logic        RESETn,
    input  logic        TSn,
    input  logic        SEL,
    input  logic        RnW,
    input  logic [1:0]  SIZ,
    input  logic [1:0]  A,
    input  logic [31:0] D_IN,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    output logic        TACKn,
    output logic        TEAn,
    output logic        PORTSIZE,
    output logic        P_CSn,
    output logic        P_UDSn,
    output logic        P_LDSn,
    output logic        P_RnW,
    output logic [15:0] P_WDATA,
    input  logic [15:0] P_RDATA,
    input  logic        P_RDYn
);

    if (WAIT_MIN < 1 || WAIT_MIN > 15 || TIMEOUT < 16 || TIMEOUT > 255) begin : g_bad_param
        $error("local_bus_word_target: WAIT_MIN or TIMEOUT out of range");
    end

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StAck, StRecover} state_t;

    state_t      state;
    logic        rnw_q;
    logic [1:0]  siz_q;
    logic [1:0]  a_q;
    logic [31:0] din_q;
    logic [3:0]  wait_cnt;

    logic        start;
    logic        is_byte;
    logic [15:0] half_word;
    logic [7:0]  byte_sel;
    logic [15:0] wdata_sel;
    logic        uds_n_sel;
    logic        lds_n_sel;
    logic        rdy;

    assign PORTSIZE = SEL;
    assign start    = !TSn && SEL;
    assign is_byte  = (siz_q == 2'b01);

    // Byte and word requests pick their half by A[1]; long and line always use the
    // upper word.
    assign half_word = (a_q[1] && (siz_q == 2'b01 || siz_q == 2'b10)) ? din_q[15:0]
                                                                      : din_q[31:16];
    // Big-endian lanes: A[0]=0 is the upper byte of the selected half.
    assign byte_sel  = a_q[0] ? half_word[7:0] : half_word[15:8];
    assign wdata_sel = is_byte ? {byte_sel, byte_sel} : half_word;
    assign uds_n_sel = is_byte && a_q[0];
    assign lds_n_sel = is_byte && !a_q[0];

    assign rdy = (wait_cnt >= 4'(WAIT_MIN - 1)) && !P_RDYn;

`ifdef TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tea_q;
    assign TEAn = tea_q;
`else
    assign TEAn = 1'b1;
`endif

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state    <= StIdle;
            rnw_q    <= 1'b1;
            siz_q    <= 2'b00;
            a_q      <= 2'b00;
            din_q    <= 32'h0;
            wait_cnt <= 4'h0;
            TACKn    <= 1'b1;
            D_OE     <= 1'b0;
            D_OUT    <= 32'h0;
            P_CSn    <= 1'b1;
            P_UDSn   <= 1'b1;
            P_LDSn   <= 1'b1;
            P_RnW    <= 1'b1;
            P_WDATA  <= 16'h0;
`ifdef TIMEOUT_EN
            tmo_cnt  <= 8'h0;
            tea_q    <= 1'b1;
`endif
        end else begin
            case (state)
                // The edge that ends RECOVER behaves as an idle edge, so a new
                // start can be taken there for back-to-back transfers.
                StIdle, StRecover: begin
                    if (start) begin
                        state <= StSetup;
                        rnw_q <= RnW;
                        siz_q <= SIZ;
                        a_q   <= A;
                        din_q <= D_IN;
                    end else begin
                        state <= StIdle;
                    end
                end
                StSetup: begin
                    state    <= StStrobe;
                    P_CSn    <= 1'b0;
                    P_UDSn   <= uds_n_sel;
                    P_LDSn   <= lds_n_sel;
                    P_RnW    <= rnw_q;
                    P_WDATA  <= wdata_sel;
                    wait_cnt <= 4'h0;
`ifdef TIMEOUT_EN
                    tmo_cnt  <= 8'h0;
`endif
                end
                StStrobe: begin
                    if (rdy) begin
                        state   <= StAck;
                        TACKn   <= 1'b0;
                        D_OUT   <= {P_RDATA, P_RDATA};
                        D_OE    <= rnw_q;
                        P_CSn   <= 1'b1;
                        P_UDSn  <= 1'b1;
                        P_LDSn  <= 1'b1;
                        P_RnW   <= 1'b1;
                        P_WDATA <= 16'h0;
                    end
`ifdef TIMEOUT_EN
                    else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        state   <= StAck;
                        tea_q   <= 1'b0;
                        D_OUT   <= rnw_q ? 32'hFFFF_FFFF : 32'h0;
                        D_OE    <= rnw_q;
                        P_CSn   <= 1'b1;
                        P_UDSn  <= 1'b1;
                        P_LDSn  <= 1'b1;
                        P_RnW   <= 1'b1;
                        P_WDATA <= 16'h0;
                    end
`endif
                    else begin
                        // Saturate so a long wait never wraps below WAIT_MIN-1.
                        if (wait_cnt != 4'hF) begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
`ifdef TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + 8'd1;
`endif
                    end
                end
                StAck: begin
                    state <= StRecover;
                    TACKn <= 1'b1;
                    D_OE  <= 1'b0;
                    D_OUT <= 32'h0;
`ifdef TIMEOUT_EN
                    tea_q <= 1'b1;
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
